// File: rtl/sprite_fb_writer.sv
// Sprite draw engine: queues draw requests, starts the sprite counter, and turns its
// pixel stream plus sprite ROM data into clipped, transparency-filtered framebuffer writes.
module sprite_fb_writer #(
    parameter int               FB_W   = 640,
    parameter int               FB_H   = 480,
    parameter int               ADDR_W = 19,
    parameter int               PIX_W  = 8,
    parameter logic [PIX_W-1:0] TRANSP = '0,
    parameter int               DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_id,
    input  logic [9:0]        req_x,
    input  logic [8:0]        req_y,
    output logic              nxt_sprt,
    input  logic              fb_en,
    input  logic              nxt,
    input  logic [4:0]        sprite_x,
    input  logic [4:0]        sprite_y,
    output logic [15:0]       rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_wdata,
    output logic              busy,
    output logic              done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int AF_W  = 21;

    typedef struct packed {
        logic [5:0] id;
        logic [9:0] x;
        logic [8:0] y;
    } req_t;

    typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

    req_t             fifo_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q, count;
    logic             full, empty, push, pop;
    state_t           state_q, state_d;
    logic             drain_q, drain_d;
    req_t             cur_q;
    logic [10:0]      ax;
    logic [9:0]       ay;
    logic [AF_W-1:0]  addr_full;
    logic             inb;
    logic             vld_p1_q, inb_p1_q;
    logic [ADDR_W-1:0] addr_p1_q;
    logic             fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [PIX_W-1:0] fb_wdata_q;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full && rst_n;
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= {req_id, req_x, req_y};
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        nxt_sprt = 1'b0;
        done     = 1'b0;
        busy     = (state_q != IDLE) || !empty;
        case (state_q)
            IDLE:  if (!empty) state_d = START;
            START: begin
                nxt_sprt = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (fb_en && nxt) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                // Two cycles let the last launched pixel reach the write port.
                if (drain_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_addr  = {cur_q.id, sprite_y, sprite_x};
    assign ax        = {1'b0, cur_q.x} + {6'd0, sprite_x};
    assign ay        = {1'b0, cur_q.y} + {5'd0, sprite_y};
    assign inb       = (ax < 11'(FB_W)) && (ay < 10'(FB_H));
    assign addr_full = AF_W'(ay) * AF_W'(FB_W) + AF_W'(ax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            drain_q    <= 1'b0;
            cur_q      <= '0;
            vld_p1_q   <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                cur_q    <= fifo_q[rd_ptr_q[PTR_W-1:0]];
            end
            state_q    <= state_d;
            drain_q    <= drain_d;
            // Stage 1 -> stage 2: ROM data arrives now, aligned with the registered address.
            vld_p1_q   <= fb_en && (state_q == RUN);
            fb_we_q    <= vld_p1_q && inb_p1_q && (rom_data != TRANSP);
            fb_addr_q  <= addr_p1_q;
            fb_wdata_q <= rom_data;
        end
    end

    always_ff @(posedge clk) begin
        inb_p1_q  <= inb;
        addr_p1_q <= ADDR_W'(addr_full);
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;

endmodule

// File: tb/tb_sprite_fb_writer.sv
// Bench for sprite_fb_writer: models the sprite counter and ROM, and predicts every
// output cycle by cycle from request/draw timing rules kept in queues.
module tb_sprite_fb_writer;
    localparam int FB_W = 640;
    localparam int FB_H = 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_id = '0;
    logic [9:0]  req_x = '0;
    logic [8:0]  req_y = '0;
    logic        nxt_sprt;
    logic        fb_en, nxt;
    logic [4:0]  sprite_x, sprite_y;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        busy, done;

    logic        cnt_en = 1'b0, cnt_nxt = 1'b0, stray_en = 1'b0, stray_nxt = 1'b0;
    logic [4:0]  cnt_x = '0, cnt_y = '0;

    assign fb_en    = cnt_en | stray_en;
    assign nxt      = cnt_nxt | stray_nxt;
    assign sprite_x = cnt_x;
    assign sprite_y = cnt_y;

    sprite_fb_writer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_x(req_x), .req_y(req_y),
        .nxt_sprt(nxt_sprt), .fb_en(fb_en), .nxt(nxt),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {int id; int x; int y; int pc;} req_t;
    typedef struct {int cyc; int addr; int data;} wr_t;

    req_t pend[$];
    req_t cur;
    wr_t  wq[$];
    int   dq[$];
    int   starts[$];
    bit   m_active = 1'b0;
    int   free_c = 0;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   rom_mode = 0;
    int   bub_lo = 5000, bub_len = 0;
    bit   rnd_bub = 1'b0;
    int   st_wr = 0, st_first_addr = -1, st_first_data = -1, st_last_addr = -1;
    int   st_done = 0, st_done_cyc = 0;
    int   last_acc = 0;

    bit   e_start, e_ready, e_busy, e_done, e_we;
    wr_t  w;

    function automatic int rom_fn(int id, int x, int y, int mode);
        case (mode)
            0:       return x + 1;
            1:       return (x % 2 == 0) ? 0 : x + 1;
            default: return (id * 7 + x * 13 + y * 5) & 255;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic tick(int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic clear_stats();
        st_wr = 0; st_first_addr = -1; st_first_data = -1; st_last_addr = -1;
        st_done = 0; st_done_cyc = 0;
        starts.delete();
    endtask

    // Leaves req_valid high; the caller decides whether another request follows.
    task automatic push_req(int id, int x, int y);
        bit ok;
        ok = 1'b0;
        req_id = 6'(id); req_x = 10'(x); req_y = 9'(y); req_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; last_acc = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!ok) chk("push_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle(int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!m_active && pend.size() == 0 && wq.size() == 0 && dq.size() == 0 && !req_valid) begin
                ok = 1'b1; break;
            end
        end
        @(posedge clk); #1;
        if (!ok) chk("idle_timeout", 32'(0), 32'(1));
    endtask

    task automatic chk_lat(string nm, int exp_gap);
        if (starts.size() > 0) chk(nm, 32'(st_done_cyc - starts[0]), 32'(exp_gap));
        else chk({nm, "_nostart"}, 32'(0), 32'(1));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sprite counter and ROM models.
    initial begin
        int n, px, py, ax, ay, d;
        bit running, bub;
        logic s_start;
        logic [15:0] s_addr;
        running = 1'b0; n = 0;
        forever begin
            @(negedge clk);
            s_start = nxt_sprt;
            s_addr  = rom_addr;
            @(posedge clk); #1;
            rom_data = 8'(rom_fn(int'(s_addr[15:10]), int'(s_addr[4:0]), int'(s_addr[9:5]), rom_mode));
            cnt_en = 1'b0; cnt_nxt = 1'b0; cnt_x = '0; cnt_y = '0;
            if (!rst_n) begin
                running = 1'b0;
            end else begin
                if (s_start) begin running = 1'b1; n = 0; end
                if (running) begin
                    px = n % 32; py = n / 32;
                    bub = (n < 1023) && ((n >= bub_lo && n < bub_lo + bub_len) ||
                                         (rnd_bub && $urandom_range(0, 15) == 0));
                    cnt_x = 5'(px); cnt_y = 5'(py);
                    cnt_en = !bub; cnt_nxt = (n == 1023);
                    if (!bub) begin
                        ax = cur.x + px; ay = cur.y + py;
                        d  = rom_fn(cur.id, px, py, rom_mode);
                        if (ax < FB_W && ay < FB_H && d != 0)
                            wq.push_back(wr_t'{cyc + 2, ay * FB_W + ax, d});
                    end
                    if (n == 1023) begin dq.push_back(cyc + 2); running = 1'b0; end
                    n++;
                end
            end
        end
    end

    // Per-cycle comparison against the timeline model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_fb_we", 32'(fb_we), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_nxt_sprt", 32'(nxt_sprt), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            pend.delete(); wq.delete(); dq.delete();
            m_active = 1'b0; free_c = 0;
        end else begin
            e_start = 1'b0;
            if (!m_active && pend.size() > 0) begin
                if (cyc >= pend[0].pc + 2 && cyc >= free_c) e_start = 1'b1;
            end
            if (e_start) begin cur = pend.pop_front(); m_active = 1'b1; end
            e_ready = (pend.size() < 4);
            e_busy  = m_active || pend.size() > 0;
            e_done  = 1'b0;
            if (dq.size() > 0) e_done = (dq[0] == cyc);
            e_we = 1'b0;
            if (wq.size() > 0) e_we = (wq[0].cyc == cyc);
            chk("nxt_sprt", 32'(nxt_sprt), 32'(e_start));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("fb_we", 32'(fb_we), 32'(e_we));
            if (e_we) begin
                w = wq.pop_front();
                chk("fb_addr", 32'(fb_addr), 32'(w.addr));
                chk("fb_wdata", 32'(fb_wdata), 32'(w.data));
            end
            if (fb_we) begin
                if (st_wr == 0) begin st_first_addr = int'(fb_addr); st_first_data = int'(fb_wdata); end
                st_last_addr = int'(fb_addr);
                st_wr++;
            end
            if (done) begin st_done++; st_done_cyc = cyc; end
            if (nxt_sprt) starts.push_back(cyc);
            if (e_done) begin void'(dq.pop_front()); m_active = 1'b0; free_c = cyc + 2; end
            if (req_valid && e_ready)
                pend.push_back(req_t'{int'(req_id), int'(req_x), int'(req_y), cyc});
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'(1));
        tick(2);

        // Single opaque sprite.
        clear_stats(); rom_mode = 0;
        push_req(3, 100, 50); req_valid = 1'b0;
        wait_idle(3000);
        chk("single_writes", 32'(st_wr), 32'(1024));
        chk("single_first_addr", 32'(st_first_addr), 32'(32100));
        chk("single_first_data", 32'(st_first_data), 32'(1));
        chk("single_last_addr", 32'(st_last_addr), 32'(51971));
        chk("single_dones", 32'(st_done), 32'(1));
        chk_lat("single_done_lat", 1026);
        if (starts.size() > 0) chk("single_start_lat", 32'(starts[0] - last_acc), 32'(2));

        // Clipping at the bottom-right corner.
        clear_stats();
        push_req(5, 620, 470); req_valid = 1'b0;
        wait_idle(3000);
        chk("clip_writes", 32'(st_wr), 32'(200));
        chk("clip_first_addr", 32'(st_first_addr), 32'(301420));
        chk("clip_last_addr", 32'(st_last_addr), 32'(307199));
        chk_lat("clip_done_lat", 1026);

        // Transparent even columns.
        clear_stats(); rom_mode = 1;
        push_req(3, 100, 50); req_valid = 1'b0;
        wait_idle(3000);
        chk("transp_writes", 32'(st_wr), 32'(512));
        chk("transp_first_addr", 32'(st_first_addr), 32'(32101));
        chk("transp_first_data", 32'(st_first_data), 32'(2));
        chk_lat("transp_done_lat", 1026);

        // FIFO fill: five back-to-back pushes, a sixth must wait.
        clear_stats(); rom_mode = 2;
        push_req($urandom_range(0, 63), $urandom_range(0, 700), $urandom_range(0, 511));
        a0 = last_acc;
        for (int i = 0; i < 4; i++)
            push_req($urandom_range(0, 63), $urandom_range(0, 700), $urandom_range(0, 511));
        req_valid = 1'b0;
        chk("fifo_b2b", 32'(last_acc - a0), 32'(4));
        @(negedge clk);
        chk("fifo_full_ready", 32'(req_ready), 32'(0));
        @(posedge clk); #1;
        push_req($urandom_range(0, 63), $urandom_range(0, 700), $urandom_range(0, 511));
        req_valid = 1'b0;
        wait_idle(8000);
        chk("fifo_dones", 32'(st_done), 32'(6));
        chk("fifo_starts", 32'(starts.size()), 32'(6));
        for (int i = 1; i < starts.size(); i++)
            chk("fifo_spacing", 32'(starts[i] - starts[i-1]), 32'(1028));

        // Stray pulses while idle, then a sprite with a 3-cycle fb_en drop.
        clear_stats(); rom_mode = 0;
        stray_en = 1'b1; stray_nxt = 1'b1;
        tick(1);
        stray_nxt = 1'b0;
        tick(1);
        stray_en = 1'b0;
        tick(4);
        chk("stray_writes", 32'(st_wr), 32'(0));
        chk("stray_starts", 32'(starts.size()), 32'(0));
        bub_lo = 200; bub_len = 3;
        push_req(7, 10, 20); req_valid = 1'b0;
        wait_idle(3000);
        bub_len = 0;
        chk("bubble_writes", 32'(st_wr), 32'(1021));
        chk("bubble_dones", 32'(st_done), 32'(1));
        chk_lat("bubble_done_lat", 1026);

        // Reset in the middle of a sprite.
        push_req(9, 300, 200); req_valid = 1'b0;
        tick(400);
        #1 rst_n = 1'b0;
        clear_stats();
        tick(3);
        #1 rst_n = 1'b1;
        tick(20);
        chk("rst_mid_writes", 32'(st_wr), 32'(0));
        chk("rst_mid_dones", 32'(st_done), 32'(0));
        chk("rst_mid_starts", 32'(starts.size()), 32'(0));
        push_req(2, 0, 0); req_valid = 1'b0;
        wait_idle(3000);
        chk("after_rst_dones", 32'(st_done), 32'(1));
        chk("after_rst_writes", 32'(st_wr), 32'(1024));

        // Randomized back-to-back sprites with random bubbles and ROM contents.
        clear_stats(); rnd_bub = 1'b1; rom_mode = 2;
        for (int i = 0; i < 6; i++)
            push_req($urandom_range(0, 63), $urandom_range(560, 1023) - $urandom_range(0, 560),
                     $urandom_range(0, 511));
        req_valid = 1'b0;
        wait_idle(12000);
        rnd_bub = 1'b0;
        chk("rand_dones", 32'(st_done), 32'(6));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
